// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the operand-fetch / subtract slice.
//   DATA_W  : datapath width of the subtractor and register file
//   NREG    : number of architectural registers
//   REG_AW  : register address width (clog2 of NREG)
//   data_t / reg_addr_t : datapath word and register index types
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int REG_AW = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: NREG x N words, two combinational read
// ports, one synchronous write port. Register 0 is hardwired to zero:
// writes to it are dropped and reads of it return 0.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (clears all words)
//   ra1/ra2 -> rd1/rd2 : read address / read data pairs
//   we, wa, wd      : write enable, write address, write data
module regfile_2r1w #(
  parameter int N    = cpu_pkg::DATA_W,
  parameter int NREG = cpu_pkg::NREG,
  parameter int AW   = cpu_pkg::REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [N-1:0]  wd
);

  logic [N-1:0] mem_q [NREG];
  logic [N-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we && (wa != '0)) begin
      mem_d[wa] = wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem_q[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem_q[ra2];

endmodule

// File: rtl/sub_operand_stage.sv
// Operand-fetch stage in front of the ripple subtractor. Holds the
// register file and borrow flag, reads rs1/rs2 (with same-cycle writeback
// bypass) on accept and presents a registered operand triple downstream.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   in_valid/in_ready               : request handshake
//   in_rs1_addr/in_rs2_addr/in_rd_addr/in_use_borrow : decoded request
//   out_valid/out_ready             : triple handshake to the subtractor
//   rs1_reg/rs2_reg/bin/out_rd_addr : registered operand triple
//   wb_en/wb_addr/wb_data           : register writeback
//   wb_flag_en/wb_bo                : borrow flag writeback
//   borrow_flag                     : current architectural borrow flag
//
// Handshake: a side transfers a beat on a rising edge where valid && ready.
// out_valid, once high, holds with every output stable until out_ready.
// in_ready = !out_valid || out_ready, so a consumed slot can be refilled in
// the same cycle and a stream flows at one triple per cycle.
module sub_operand_stage #(
  parameter int N    = cpu_pkg::DATA_W,
  parameter int NREG = cpu_pkg::NREG,
  parameter int AW   = cpu_pkg::REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs1_addr,
  input  logic [AW-1:0] in_rs2_addr,
  input  logic [AW-1:0] in_rd_addr,
  input  logic          in_use_borrow,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  rs1_reg,
  output logic [N-1:0]  rs2_reg,
  output logic          bin,
  output logic [AW-1:0] out_rd_addr,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [N-1:0]  wb_data,
  input  logic          wb_flag_en,
  input  logic          wb_bo,
  output logic          borrow_flag
);

  import cpu_pkg::*;

  logic [N-1:0]  rf_rd1;
  logic [N-1:0]  rf_rd2;
  logic [N-1:0]  rs1_val;
  logic [N-1:0]  rs2_val;
  logic          bin_val;
  logic          accept;

  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  rs1_q, rs1_d;
  logic [N-1:0]  rs2_q, rs2_d;
  logic          bin_q, bin_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          borrow_q, borrow_d;

  regfile_2r1w #(
    .N    (N),
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (in_rs1_addr),
    .ra2 (in_rs2_addr),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (wb_en),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // Same-cycle writeback forwarding; r0 is never forwarded.
    rs1_val = rf_rd1;
    rs2_val = rf_rd2;
    if (wb_en && (wb_addr == in_rs1_addr) && (in_rs1_addr != '0)) begin
      rs1_val = wb_data;
    end
    if (wb_en && (wb_addr == in_rs2_addr) && (in_rs2_addr != '0)) begin
      rs2_val = wb_data;
    end
    // Borrow-in sees a flag update landing in the same cycle.
    bin_val = 1'b0;
    if (in_use_borrow) begin
      bin_val = wb_flag_en ? wb_bo : borrow_q;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    bin_d       = bin_q;
    rd_d        = rd_q;
    borrow_d    = borrow_q;
    if (accept) begin
      out_valid_d = 1'b1;
      rs1_d       = rs1_val;
      rs2_d       = rs2_val;
      bin_d       = bin_val;
      rd_d        = in_rd_addr;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (wb_flag_en) begin
      borrow_d = wb_bo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      bin_q       <= 1'b0;
      rd_q        <= '0;
      borrow_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      bin_q       <= bin_d;
      rd_q        <= rd_d;
      borrow_q    <= borrow_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign rs1_reg     = rs1_q;
  assign rs2_reg     = rs2_q;
  assign bin         = bin_q;
  assign out_rd_addr = rd_q;
  assign borrow_flag = borrow_q;

endmodule

// File: tb/tb_sub_operand_stage.sv
module tb_sub_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_rs1_addr;
  logic [2:0]  in_rs2_addr;
  logic [2:0]  in_rd_addr;
  logic        in_use_borrow;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] rs1_reg;
  logic [15:0] rs2_reg;
  logic        bin;
  logic [2:0]  out_rd_addr;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        wb_flag_en;
  logic        wb_bo;
  logic        borrow_flag;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state plus the single held triple.
  logic [15:0] m_rf [8];
  logic        m_flag;
  logic        m_valid;
  logic [15:0] m_rs1;
  logic [15:0] m_rs2;
  logic        m_bin;
  logic [2:0]  m_rd;

  sub_operand_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs1_addr   (in_rs1_addr),
    .in_rs2_addr   (in_rs2_addr),
    .in_rd_addr    (in_rd_addr),
    .in_use_borrow (in_use_borrow),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .rs1_reg       (rs1_reg),
    .rs2_reg       (rs2_reg),
    .bin           (bin),
    .out_rd_addr   (out_rd_addr),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .wb_flag_en    (wb_flag_en),
    .wb_bo         (wb_bo),
    .borrow_flag   (borrow_flag)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_flag  = 1'b0;
    m_valid = 1'b0;
    m_rs1   = 16'h0;
    m_rs2   = 16'h0;
    m_bin   = 1'b0;
    m_rd    = 3'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_req(input logic v, input logic [2:0] a1, input logic [2:0] a2,
                         input logic [2:0] rd, input logic ub, input logic ordy);
    in_valid      = v;
    in_rs1_addr   = a1;
    in_rs2_addr   = a2;
    in_rd_addr    = rd;
    in_use_borrow = ub;
    out_ready     = ordy;
  endtask

  task automatic set_wb(input logic en, input logic [2:0] a, input logic [15:0] d,
                        input logic fen, input logic bo);
    wb_en      = en;
    wb_addr    = a;
    wb_data    = d;
    wb_flag_en = fen;
    wb_bo      = bo;
  endtask

  task automatic idle();
    set_req(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    set_wb(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [15:0] read_op(input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  // One clock cycle: inputs are already applied. Check the combinational
  // ready, advance the model across the edge, then check the outputs.
  task automatic do_cycle(input string tag);
    logic        rdy, acc;
    logic [15:0] n1, n2;
    logic        nb;
    #1;
    rdy = !m_valid || out_ready;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    acc = in_valid && rdy;
    n1  = read_op(in_rs1_addr);
    n2  = read_op(in_rs2_addr);
    nb  = in_use_borrow ? (wb_flag_en ? wb_bo : m_flag) : 1'b0;
    @(posedge clk);
    if (acc) begin
      m_valid = 1'b1;
      m_rs1   = n1;
      m_rs2   = n2;
      m_bin   = nb;
      m_rd    = in_rd_addr;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (wb_en && wb_addr != 3'd0) m_rf[wb_addr] = wb_data;
    if (wb_flag_en) m_flag = wb_bo;
    #1;
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    chk({tag, ".borrow_flag"}, {31'd0, borrow_flag}, {31'd0, m_flag});
    if (m_valid) begin
      chk({tag, ".rs1_reg"}, {16'd0, rs1_reg}, {16'd0, m_rs1});
      chk({tag, ".rs2_reg"}, {16'd0, rs2_reg}, {16'd0, m_rs2});
      chk({tag, ".bin"}, {31'd0, bin}, {31'd0, m_bin});
      chk({tag, ".rd"}, {29'd0, out_rd_addr}, {29'd0, m_rd});
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.rs1_reg", {16'd0, rs1_reg}, 32'd0);
    chk("reset.rs2_reg", {16'd0, rs2_reg}, 32'd0);
    chk("reset.bin", {31'd0, bin}, 32'd0);
    chk("reset.rd", {29'd0, out_rd_addr}, 32'd0);
    chk("reset.borrow_flag", {31'd0, borrow_flag}, 32'd0);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // Basic path
    set_wb(1'b1, 3'd1, 16'h0005, 1'b0, 1'b0); do_cycle("wb_r1");
    set_wb(1'b1, 3'd2, 16'h0003, 1'b0, 1'b0); do_cycle("wb_r2");
    set_wb(1'b1, 3'd4, 16'h1111, 1'b0, 1'b0); do_cycle("wb_r4");
    idle();
    set_req(1'b1, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1); do_cycle("basic");
    chk("basic.rs1_direct", {16'd0, rs1_reg}, 32'h0005);
    chk("basic.rs2_direct", {16'd0, rs2_reg}, 32'h0003);

    // Bypass: r4 written in the accept cycle, both sources hit r4
    set_req(1'b1, 3'd4, 3'd4, 3'd5, 1'b0, 1'b1);
    set_wb(1'b1, 3'd4, 16'hBEEF, 1'b0, 1'b0); do_cycle("bypass");
    chk("bypass.rs1_direct", {16'd0, rs1_reg}, 32'hBEEF);

    // Borrow chain
    set_req(1'b1, 3'd1, 3'd2, 3'd6, 1'b1, 1'b1);
    set_wb(1'b0, 3'd0, 16'h0, 1'b1, 1'b1); do_cycle("borrow_k");
    chk("borrow_k.bin_direct", {31'd0, bin}, 32'd1);
    set_req(1'b1, 3'd1, 3'd2, 3'd6, 1'b0, 1'b1);
    set_wb(1'b0, 3'd0, 16'h0, 1'b0, 1'b0); do_cycle("borrow_k1");
    chk("borrow_k1.bin_direct", {31'd0, bin}, 32'd0);
    chk("borrow_k1.flag_direct", {31'd0, borrow_flag}, 32'd1);
    set_req(1'b1, 3'd2, 3'd1, 3'd7, 1'b1, 1'b1); do_cycle("borrow_flag_use");

    // Backpressure: hold in_valid, writes during stall must not touch the triple
    set_req(1'b1, 3'd1, 3'd4, 3'd2, 1'b0, 1'b1); do_cycle("bp_load");
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 3'd2, 3'd1, 3'd4, 1'b1, 1'b0);
      set_wb(1'b1, 3'd1, 16'h7000 + 16'(i), 1'b1, 1'(i));
      do_cycle("bp_stall");
      chk("bp_stall.in_ready_direct", {31'd0, in_ready}, 32'd0);
      chk("bp_stall.rs1_held", {16'd0, rs1_reg}, 32'h0005);
    end
    set_wb(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    set_req(1'b1, 3'd2, 3'd1, 3'd4, 1'b1, 1'b1); do_cycle("bp_release");
    chk("bp_release.valid_direct", {31'd0, out_valid}, 32'd1);
    idle(); do_cycle("drain");

    // r0: write ignored, read returns zero, no bypass into r0
    set_wb(1'b1, 3'd0, 16'hFFFF, 1'b0, 1'b0); do_cycle("wb_r0");
    set_req(1'b1, 3'd0, 3'd0, 3'd1, 1'b0, 1'b1); do_cycle("read_r0");
    chk("read_r0.rs1_direct", {16'd0, rs1_reg}, 32'h0);
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      set_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      set_wb(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      do_cycle("rand");
    end

    // Reset while a triple is held, after making flag and registers non-zero
    set_req(1'b1, 3'd3, 3'd5, 3'd1, 1'b1, 1'b0);
    set_wb(1'b1, 3'd7, 16'hA5A5, 1'b1, 1'b1); do_cycle("pre_rst_a");
    set_req(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    set_wb(1'b0, 3'd0, 16'h0, 1'b0, 1'b0); do_cycle("pre_rst_b");
    chk("pre_rst.valid_direct", {31'd0, out_valid}, 32'd1);
    chk("pre_rst.flag_direct", {31'd0, borrow_flag}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst.borrow_flag", {31'd0, borrow_flag}, 32'd0);
    chk("async_rst.rs1_reg", {16'd0, rs1_reg}, 32'd0);
    chk("async_rst.bin", {31'd0, bin}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    for (int r = 1; r < 8; r += 2) begin
      set_req(1'b1, 3'(r), 3'((r + 1) % 8), 3'(r), 1'b1, 1'b1);
      do_cycle("post_rst_read");
      chk("post_rst.rs1_direct", {16'd0, rs1_reg}, 32'd0);
    end
    idle(); do_cycle("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
